// File: rtl/sublime_pkg.sv
// Shared frame geometry, slot index type and helpers for the Sublime I2S transmitter.
package sublime_pkg;

    localparam int unsigned FRAME_SLOTS = 64;
    localparam int unsigned CHAN_SLOTS  = 32;

    typedef logic [$clog2(FRAME_SLOTS)-1:0] slot_t;
    typedef logic [FRAME_SLOTS-1:0]         frame_t;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    function automatic chan_e chan_of(slot_t s);
        return (s < slot_t'(CHAN_SLOTS)) ? CH_LEFT : CH_RIGHT;
    endfunction

    // Keeps the top 'width' bits of a 32-bit sample; the rest go out as zeros.
    function automatic logic [31:0] sample_mask(int unsigned width);
        return 32'hFFFF_FFFF << (32 - width);
    endfunction

endpackage

// File: rtl/sublime_i2s_clkgen.sv
// Bit-clock divider and 64-slot frame counter; emits per-slot and per-frame start strobes
// in the cycle whose closing edge makes bclk fall.
module sublime_i2s_clkgen
    import sublime_pkg::*;
#(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    output logic  bclk_o,
    output logic  slot_stb_o,
    output logic  frame_stb_o,
    output slot_t slot_o
);

    localparam int unsigned       DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    slot_t            slot_q, slot_d;
    logic             wrap;

    always_comb begin
        wrap        = (div_q == DIV_LAST);
        div_d       = wrap ? '0 : div_q + 1'b1;
        bclk_d      = wrap ? ~bclk_q : bclk_q;
        slot_stb_o  = wrap & bclk_q;
        frame_stb_o = slot_stb_o && (slot_q == slot_t'(FRAME_SLOTS - 1));
        slot_d      = slot_stb_o ? slot_q + 1'b1 : slot_q;
        slot_o      = slot_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
            slot_q <= '1;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
            slot_q <= slot_d;
        end
    end

    assign bclk_o = bclk_q;

endmodule

// File: rtl/sublime_i2s_tx.sv
// Philips I2S stereo transmitter with sample handshake and sticky underrun flag.
// Define SUBLIME_I2S_TX_HOLD_EN to repeat the last loaded samples on underrun (default: zeros).
module sublime_i2s_tx
    import sublime_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 24,
    parameter int unsigned BCLK_DIV     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] left_sample,
    input  logic [31:0] right_sample,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic        underrun_clr,
    output logic        underrun,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata
);

    localparam logic [31:0] MASK = sample_mask(SAMPLE_WIDTH);

    logic   slot_stb, frame_stb;
    slot_t  slot;
    frame_t sh_q, sh_d, new_frame, ur_frame;
    logic   sdata_q, sdata_d;
    logic   lrclk_q, lrclk_d;
    logic   ready_q, ready_d;
    logic   underrun_q, underrun_d;

    sublime_i2s_clkgen #(
        .BCLK_DIV(BCLK_DIV)
    ) u_clkgen (
        .clk_i      (clk),
        .rst_ni     (rst),
        .bclk_o     (i2s_bclk),
        .slot_stb_o (slot_stb),
        .frame_stb_o(frame_stb),
        .slot_o     (slot)
    );

    assign new_frame = {left_sample & MASK, right_sample & MASK};

`ifdef SUBLIME_I2S_TX_HOLD_EN
    frame_t hold_q, hold_d;

    always_comb begin
        hold_d = hold_q;
        if (frame_stb && sample_valid) hold_d = new_frame;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hold_q <= '0;
        else      hold_q <= hold_d;
    end

    assign ur_frame = hold_q;
`else
    assign ur_frame = '0;
`endif

    // The MSB leaving the shifter lags its slot by one bclk, which yields the I2S delay;
    // at frame start the old right LSB still goes out while the new frame is loaded.
    always_comb begin
        sh_d       = sh_q;
        sdata_d    = sdata_q;
        lrclk_d    = lrclk_q;
        ready_d    = 1'b0;
        underrun_d = underrun_clr ? 1'b0 : underrun_q;
        if (slot_stb) begin
            sdata_d = sh_q[FRAME_SLOTS-1];
            lrclk_d = (chan_of(slot) == CH_RIGHT);
            sh_d    = {sh_q[FRAME_SLOTS-2:0], 1'b0};
            if (frame_stb) begin
                if (sample_valid) begin
                    sh_d    = new_frame;
                    ready_d = 1'b1;
                end else begin
                    sh_d       = ur_frame;
                    underrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q       <= '0;
            sdata_q    <= 1'b0;
            lrclk_q    <= 1'b1;
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            sh_q       <= sh_d;
            sdata_q    <= sdata_d;
            lrclk_q    <= lrclk_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
        end
    end

    assign sample_ready = ready_q;
    assign underrun     = underrun_q;
    assign i2s_lrclk    = lrclk_q;
    assign i2s_sdata    = sdata_q;

endmodule

// File: doc/sublime_i2s_tx.md
SUBLIME_I2S_TX -- requirements
Module: sublime_i2s_tx

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 24: number of MSBs of each 32-bit sample transmitted per channel (1..32).
REQ-002 SHALL have parameter BCLK_DIV, default 4: clk cycles per bclk half-period (>=1).
REQ-003 SHALL have port clk, input, 1: sole clock.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port left_sample, input, 32: left sample from the synthesizer top.
REQ-006 SHALL have port right_sample, input, 32: right sample.
REQ-007 SHALL have port sample_valid, input, 1: left/right samples are valid.
REQ-008 SHALL have port sample_ready, output, 1: one-cycle pulse marking the samples as consumed.
REQ-009 SHALL have port underrun_clr, input, 1: clears the underrun flag.
REQ-010 SHALL have port underrun, output, 1: sticky flag, a frame started without valid samples.
REQ-011 SHALL have ports i2s_bclk, i2s_lrclk, i2s_sdata, outputs, 1 each: Philips I2S bit clock, word select, serial data.

Function
REQ-012 SHALL run a divider counting 0..BCLK_DIV-1 and toggle i2s_bclk in the cycle the divider wraps; bclk period = 2*BCLK_DIV clk.
REQ-013 SHALL keep a 6-bit slot counter advancing (63 wraps to 0) on each bclk falling toggle; a frame is 64 slots, 32 per channel.
REQ-014 SHALL update i2s_lrclk and i2s_sdata only in the cycle bclk falls; lrclk = 0 for slots 0-31 (left) and 1 for slots 32-63 (right).
REQ-015 SHALL drive in slot n the bit of slot n-1 (one-bclk I2S delay): left MSB in slot 1, right MSB in slot 33, MSB first.
REQ-016 SHALL transmit per channel bits [31:32-SAMPLE_WIDTH] followed by zeros for the remaining 32-SAMPLE_WIDTH slots; no rounding.
REQ-017 SHALL evaluate sample_valid in the cycle slot 0 begins: if high, load both samples into the frame shift register and pulse sample_ready high for exactly that cycle.
REQ-018 SHALL, if sample_valid is low at slot 0, keep sample_ready low, set underrun, and load the underrun frame per REQ-024.
REQ-019 SHALL ignore sample_valid at all other times; inputs may change freely outside the slot-0 cycle.
REQ-020 SHALL give setting priority over underrun_clr when an underrun and underrun_clr coincide in the same cycle.
REQ-021 SHALL drive the last bit of the previous frame's right channel (always 0 when SAMPLE_WIDTH<32) in slot 0.

Reset
REQ-022 SHALL, while rst is low, force i2s_bclk=0, i2s_lrclk=1, i2s_sdata=0, sample_ready=0, underrun=0, divider=0, slot counter=63, shift register=0.
REQ-023 SHALL, after rst rises, produce the first bclk falling edge and slot 0 (first sample load) 2*BCLK_DIV clk cycles later; reset mid-frame aborts the frame with no further sample_ready.

Configuration
REQ-024 SHALL, with SUBLIME_I2S_TX_HOLD_EN defined, retransmit the previously loaded samples on underrun; without it, transmit an all-zero frame on underrun.

Structure
REQ-025 SHALL place the frame length (64), channel slot count (32), and a slot-index typedef in a shared sublime_pkg package.
REQ-026 SHALL isolate the divider/bclk/slot generation in one sub-module sublime_i2s_clkgen, which outputs slot-start strobes to the serializer.

Verification
REQ-027 SHALL cover BCLK_DIV=2, SAMPLE_WIDTH=24, L=0xA5C3F0xx, R=0x0F1E2Dxx, valid held -> after lrclk falls, sdata bits in slots 1-24 equal A5C3F0 MSB-first, slots 25-32 are 0, slots 33-56 equal 0F1E2D.
REQ-028 SHALL cover reset release with valid high -> first sample_ready exactly 4 clk after release (BCLK_DIV=2), then one pulse every 256 clk.
REQ-029 SHALL cover valid dropped for one frame -> underrun=1, no sample_ready that frame, and data all zero (macro off) or a repeat of the prior frame (macro on).
REQ-030 SHALL cover underrun_clr asserted in the same cycle as a new underrun -> underrun stays 1; asserted alone -> 0 the next cycle.
REQ-031 SHALL cover rst asserted at slot 40 -> outputs immediately at reset values, and the restart timing equals that of REQ-028.
REQ-032 SHALL cover SAMPLE_WIDTH=32, BCLK_DIV=1, L=0x80000001 -> slot 32 carries 1 and slot 0 of the next frame carries the right-channel LSB.
